// File: rtl/branch_predictor.sv
// branch_predictor
// Gshare branch predictor with EX-stage resolution for the 5-stage pipeline.
// A table of 2-bit saturating counters, indexed by PC[IDX_W+1:2] XOR the
// global history (history in the high index bits), predicts the ID branch.
// The prediction travels into EX with the branch. There it is compared with
// the real outcome to produce the wrong-predict flag and the recovery PC.
// The table, history and statistics train when the branch leaves EX.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   ID_Branch_i          ID instruction is a conditional branch
//   ID_PC_i, ID_Target_i ID branch PC and target
//   ID_PredTaken_o       combinational prediction for the ID branch
//   WriteEX_i            EX register write enable
//   FlushEX_i            EX register flush (wins over hold)
//   WriteMEM_i           EX instruction advances to MEM this cycle
//   EX_BranchTaken_i     actual outcome of the EX branch
//   EX_WrongPredict_o    EX branch mispredicted (combinational)
//   EX_RecoverPC_o       correct next PC for the EX branch (combinational)
//   BrCount_o            saturating count of resolved branches
//   MissCount_o          saturating count of mispredictions
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int HIST_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_Branch_i,
    input  logic [31:0] ID_PC_i,
    input  logic [31:0] ID_Target_i,
    output logic        ID_PredTaken_o,
    input  logic        WriteEX_i,
    input  logic        FlushEX_i,
    input  logic        WriteMEM_i,
    input  logic        EX_BranchTaken_i,
    output logic        EX_WrongPredict_o,
    output logic [31:0] EX_RecoverPC_o,
    output logic [15:0] BrCount_o,
    output logic [15:0] MissCount_o
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [1:0]       counters [ENTRIES];
    logic [IDX_W-1:0] histPad;
    logic [IDX_W-1:0] idIdx;
    logic             exValid;
    logic             exPred;
    logic [IDX_W-1:0] exIdx;
    logic [31:0]      exPc;
    logic [31:0]      exTarget;
    logic             retire;

    // Only the index bits of the PC feed the table.
    logic unusedPcBits;
    assign unusedPcBits = ^{ID_PC_i[31:IDX_W+2], ID_PC_i[1:0]};

    assign retire = exValid & WriteMEM_i;

    generate
        if (HIST_W > 0) begin : g_hist
            logic [HIST_W-1:0] ghr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ghr <= '0;
                end else if (retire) begin
                    // Shift left; the oldest outcome falls off the top.
                    ghr <= (ghr << 1) | HIST_W'(EX_BranchTaken_i);
                end
            end

            // History occupies the high index bits, zero padding below.
            assign histPad = IDX_W'(ghr) << (IDX_W - HIST_W);
        end else begin : g_nohist
            assign histPad = '0;
        end
    endgenerate

    assign idIdx          = ID_PC_i[IDX_W+1:2] ^ histPad;
    // Read is the registered table value: a same-cycle retire to the same
    // entry is not bypassed.
    assign ID_PredTaken_o = ID_Branch_i & counters[idIdx][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters[i] <= 2'b01;
            end
        end else if (retire) begin
            if (EX_BranchTaken_i) begin
                if (counters[exIdx] != 2'b11) begin
                    counters[exIdx] <= counters[exIdx] + 2'd1;
                end
            end else begin
                if (counters[exIdx] != 2'b00) begin
                    counters[exIdx] <= counters[exIdx] - 2'd1;
                end
            end
        end
    end

    // Flush clears only the valid bit; the other fields are don't-care then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exValid  <= 1'b0;
            exPred   <= 1'b0;
            exIdx    <= '0;
            exPc     <= '0;
            exTarget <= '0;
        end else if (FlushEX_i) begin
            exValid  <= 1'b0;
        end else if (WriteEX_i) begin
            exValid  <= ID_Branch_i;
            exPred   <= ID_PredTaken_o;
            exIdx    <= idIdx;
            exPc     <= ID_PC_i;
            exTarget <= ID_Target_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BrCount_o   <= '0;
            MissCount_o <= '0;
        end else if (retire) begin
            if (BrCount_o != 16'hFFFF) begin
                BrCount_o <= BrCount_o + 16'd1;
            end
            if (EX_WrongPredict_o && (MissCount_o != 16'hFFFF)) begin
                MissCount_o <= MissCount_o + 16'd1;
            end
        end
    end

    assign EX_WrongPredict_o = exValid & (exPred != EX_BranchTaken_i);
    assign EX_RecoverPC_o    = EX_BranchTaken_i ? exTarget : exPc + 32'd4;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor. Instance 0 is a bimodal table (HIST_W=0).
// Instance 1 is the default gshare (HIST_W=4). Both share the same inputs.
module tb_branch_predictor;
    localparam int ENTRIES = 64;
    localparam int IDX_W   = $clog2(ENTRIES);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        idBranch = 1'b0;
    logic [31:0] idPc = '0;
    logic [31:0] idTarget = '0;
    logic        writeEx = 1'b0;
    logic        flushEx = 1'b0;
    logic        writeMem = 1'b0;
    logic        exTaken = 1'b0;

    logic        predO  [2];
    logic        wrongO [2];
    logic [31:0] recO   [2];
    logic [15:0] brO    [2];
    logic [15:0] missO  [2];

    int nCmp = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES), .HIST_W(0)) dut0 (
        .clk(clk), .rst(rst),
        .ID_Branch_i(idBranch), .ID_PC_i(idPc), .ID_Target_i(idTarget),
        .ID_PredTaken_o(predO[0]),
        .WriteEX_i(writeEx), .FlushEX_i(flushEx), .WriteMEM_i(writeMem),
        .EX_BranchTaken_i(exTaken),
        .EX_WrongPredict_o(wrongO[0]), .EX_RecoverPC_o(recO[0]),
        .BrCount_o(brO[0]), .MissCount_o(missO[0])
    );

    branch_predictor #(.ENTRIES(ENTRIES), .HIST_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .ID_Branch_i(idBranch), .ID_PC_i(idPc), .ID_Target_i(idTarget),
        .ID_PredTaken_o(predO[1]),
        .WriteEX_i(writeEx), .FlushEX_i(flushEx), .WriteMEM_i(writeMem),
        .EX_BranchTaken_i(exTaken),
        .EX_WrongPredict_o(wrongO[1]), .EX_RecoverPC_o(recO[1]),
        .BrCount_o(brO[1]), .MissCount_o(missO[1])
    );

    // Reference model: counters as integers 0..3, history as an integer of
    // past outcomes (newest in the LSB).
    int          tbl [2][ENTRIES];
    int          mGhr [2];
    bit          mExValid [2];
    bit          mExPred [2];
    int          mExIdx [2];
    logic [31:0] mExPc;
    logic [31:0] mExTarget;
    bit          exKnown;
    int          mBr [2];
    int          mMiss [2];

    function automatic int histW(int k);
        return (k == 0) ? 0 : 4;
    endfunction

    function automatic int mIdx(int k, logic [31:0] pc);
        int h;
        int base;
        h    = histW(k);
        base = int'((pc >> 2) % ENTRIES);
        return base ^ ((mGhr[k] % (1 << h)) << (IDX_W - h));
    endfunction

    function automatic bit mPredict(int k, bit br, logic [31:0] pc);
        return br && (tbl[k][mIdx(k, pc)] >= 2);
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < ENTRIES; i++) tbl[k][i] = 1;
            mGhr[k] = 0; mExValid[k] = 0; mExPred[k] = 0; mExIdx[k] = 0;
            mBr[k] = 0; mMiss[k] = 0;
        end
        mExPc = '0; mExTarget = '0; exKnown = 1;
    endtask

    task automatic modelEdge();
        int idI [2];
        bit idP [2];
        for (int k = 0; k < 2; k++) begin
            idI[k] = mIdx(k, idPc);
            idP[k] = mPredict(k, idBranch, idPc);
        end
        for (int k = 0; k < 2; k++) begin
            if (mExValid[k] && writeMem) begin
                if (exTaken) tbl[k][mExIdx[k]] = (tbl[k][mExIdx[k]] == 3) ? 3 : tbl[k][mExIdx[k]] + 1;
                else         tbl[k][mExIdx[k]] = (tbl[k][mExIdx[k]] == 0) ? 0 : tbl[k][mExIdx[k]] - 1;
                mGhr[k] = (mGhr[k] * 2 + int'(exTaken)) % (1 << histW(k));
                if (mBr[k] < 65535) mBr[k]++;
                if (mExPred[k] != exTaken && mMiss[k] < 65535) mMiss[k]++;
            end
        end
        if (flushEx) begin
            for (int k = 0; k < 2; k++) mExValid[k] = 0;
            exKnown = 0;
        end else if (writeEx) begin
            for (int k = 0; k < 2; k++) begin
                mExValid[k] = idBranch;
                mExPred[k]  = idP[k];
                mExIdx[k]   = idI[k];
            end
            mExPc = idPc; mExTarget = idTarget; exKnown = 1;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pred%0d", k), 32'(predO[k]), 32'(mPredict(k, idBranch, idPc)));
            chk($sformatf("wrong%0d", k), 32'(wrongO[k]), 32'(mExValid[k] && (mExPred[k] != exTaken)));
            if (exKnown)
                chk($sformatf("recover%0d", k), recO[k], exTaken ? mExTarget : mExPc + 32'd4);
            chk($sformatf("brCount%0d", k), 32'(brO[k]), 32'(mBr[k]));
            chk($sformatf("missCount%0d", k), 32'(missO[k]), 32'(mMiss[k]));
        end
    endtask

    task automatic setIn(bit br, logic [31:0] pc, logic [31:0] tgt, bit wex, bit fl, bit wmem, bit tk);
        idBranch = br; idPc = pc; idTarget = tgt;
        writeEx = wex; flushEx = fl; writeMem = wmem; exTaken = tk;
    endtask

    task automatic sample();
        @(negedge clk);
        checkAll();
    endtask

    task automatic advance();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        modelReset();
        #1;
        chk("rstWrong0", 32'(wrongO[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        bit          br;
        logic [31:0] pc;
        logic [31:0] tgt;
        bit          wex, fl, wmem, tk;
        bit          ePred, eWrong;
        logic [31:0] eRec;
        int          eBr, eMiss;
    } vec_t;

    vec_t vecs [14];

    initial begin
        // Bimodal training/saturation on PC 0x40 (index 16), one branch at a
        // time with a bubble between so each resolves before the next lookup.
        vecs[0]  = '{1, 32'h40, 32'h80, 1, 0, 0, 0, 0, 0, 32'h4,  0, 0};
        vecs[1]  = '{0, 32'h0,  32'h0,  1, 0, 1, 1, 0, 1, 32'h80, 0, 0};
        vecs[2]  = '{1, 32'h40, 32'h80, 1, 0, 0, 0, 1, 0, 32'h4,  1, 1};
        vecs[3]  = '{0, 32'h0,  32'h0,  1, 0, 1, 1, 0, 0, 32'h80, 1, 1};
        vecs[4]  = '{1, 32'h40, 32'h80, 1, 0, 0, 0, 1, 0, 32'h4,  2, 1};
        vecs[5]  = '{0, 32'h0,  32'h0,  1, 0, 1, 1, 0, 0, 32'h80, 2, 1};
        vecs[6]  = '{1, 32'h40, 32'h80, 0, 0, 0, 0, 1, 0, 32'h4,  3, 1};
        vecs[7]  = '{1, 32'h40, 32'h80, 1, 0, 0, 0, 1, 0, 32'h4,  3, 1};
        vecs[8]  = '{0, 32'h0,  32'h0,  1, 0, 1, 1, 0, 0, 32'h80, 3, 1};
        vecs[9]  = '{1, 32'h40, 32'h80, 1, 0, 0, 0, 1, 0, 32'h4,  4, 1};
        vecs[10] = '{0, 32'h0,  32'h0,  1, 0, 1, 1, 0, 0, 32'h80, 4, 1};
        vecs[11] = '{1, 32'h40, 32'h80, 1, 0, 0, 0, 1, 0, 32'h4,  5, 1};
        vecs[12] = '{0, 32'h0,  32'h0,  1, 0, 1, 0, 0, 1, 32'h44, 5, 1};
        vecs[13] = '{1, 32'h40, 32'h80, 0, 0, 0, 0, 1, 0, 32'h4,  6, 2};

        setIn(0, 0, 0, 0, 0, 0, 0);
        doReset();

        for (int i = 0; i < 14; i++) begin
            setIn(vecs[i].br, vecs[i].pc, vecs[i].tgt, vecs[i].wex, vecs[i].fl, vecs[i].wmem, vecs[i].tk);
            sample();
            chk($sformatf("vec%0d.pred", i),   32'(predO[0]),  32'(vecs[i].ePred));
            chk($sformatf("vec%0d.wrong", i),  32'(wrongO[0]), 32'(vecs[i].eWrong));
            chk($sformatf("vec%0d.recover", i), recO[0],       vecs[i].eRec);
            chk($sformatf("vec%0d.br", i),     32'(brO[0]),    32'(vecs[i].eBr));
            chk($sformatf("vec%0d.miss", i),   32'(missO[0]),  32'(vecs[i].eMiss));
            advance();
        end

        // Mispredicted branch (PC 0x100, counter 01, actually taken) held in EX.
        setIn(1, 32'h100, 32'h200, 1, 0, 0, 0);
        sample(); advance();
        for (int i = 0; i < 3; i++) begin
            setIn(0, 0, 0, 0, 0, 0, 1);
            sample();
            chk("stallWrong", 32'(wrongO[0]), 32'd1);
            chk("stallRecover", recO[0], 32'h200);
            chk("stallBr", 32'(brO[0]), 32'd6);
            advance();
        end
        setIn(0, 0, 0, 1, 0, 1, 1);
        sample();
        chk("releaseWrong", 32'(wrongO[0]), 32'd1);
        advance();
        setIn(0, 0, 0, 1, 0, 0, 0);
        sample();
        chk("afterStallBr", 32'(brO[0]), 32'd7);
        chk("afterStallMiss", 32'(missO[0]), 32'd3);
        advance();

        // Flush a predicted-taken branch in ID; it must not reach EX.
        setIn(1, 32'h100, 32'h200, 1, 1, 0, 0);
        sample();
        chk("flushIdPred", 32'(predO[0]), 32'd1);
        advance();
        setIn(0, 0, 0, 1, 0, 1, 0);
        sample();
        chk("flushWrong", 32'(wrongO[0]), 32'd0);
        advance();
        setIn(1, 32'h100, 32'h200, 0, 0, 0, 0);
        sample();
        chk("flushBr", 32'(brO[0]), 32'd7);
        chk("flushMiss", 32'(missO[0]), 32'd3);
        chk("flushPred", 32'(predO[0]), 32'd1);
        advance();

        // Wrap: train index 63 to weakly taken, then resolve not-taken.
        setIn(1, 32'hFFFF_FFFC, 32'h10, 1, 0, 0, 0);
        sample(); advance();
        setIn(0, 0, 0, 1, 0, 1, 1);
        sample(); advance();
        setIn(1, 32'hFFFF_FFFC, 32'h10, 1, 0, 0, 0);
        sample();
        chk("wrapIdPred", 32'(predO[0]), 32'd1);
        advance();
        setIn(0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("wrapWrong", 32'(wrongO[0]), 32'd1);
        chk("wrapRecover", recO[0], 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("midRstWrong0", 32'(wrongO[0]), 32'd0);
        chk("midRstWrong1", 32'(wrongO[1]), 32'd0);
        chk("midRstBr", 32'(brO[0]), 32'd0);
        chk("midRstMiss", 32'(missO[0]), 32'd0);
        modelReset();
        setIn(0, 0, 0, 1, 0, 1, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        setIn(1, 32'hFFFF_FFFC, 32'h10, 0, 0, 0, 0);
        sample();
        chk("postRstPred", 32'(predO[0]), 32'd0);
        chk("postRstBr", 32'(brO[0]), 32'd0);
        advance();

        // Random traffic against the model; small PC pool to force aliasing
        // and same-cycle lookup/update collisions.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            if ($urandom_range(0, 499) == 0) begin
                setIn(0, 0, 0, 0, 0, 0, 0);
                doReset();
            end
            pc = 32'($urandom_range(0, 127)) << 2;
            if ($urandom_range(0, 7) == 0) pc = pc | ($urandom & 32'hFFFF_FE00);
            setIn($urandom_range(0, 3) != 0, pc, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            sample();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
        $finish;
    end
endmodule
